// File: rtl/pipelined_wide_adder.sv
// Pipelined wide adder/subtractor with valid/ready handshaking.
// The (WA+1)-bit sum is built one SEG-bit segment per stage, LSB first; each
// stage consumes the carry registered by the stage before it. Operand bits not
// yet consumed, the finished low sum bits, the mode and the tag move down the
// pipe with the operation. Subtraction is A + ~zext(B) + 1: every stage inverts
// its B segment when the mode is 1, and the stage-0 carry-in is the mode bit.
module pipelined_wide_adder #(
    parameter int WA   = 37,
    parameter int WB   = 35,
    parameter int SEG  = 16,
    parameter int TAGW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_mode,
    input  logic [WA-1:0]   in_a,
    input  logic [WB-1:0]   in_b,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [WA:0]     out_sum,
    output logic [TAGW-1:0] out_tag
);
    localparam int W    = WA + 1;
    localparam int NSEG = (W + SEG - 1) / SEG;

    if (WB > WA) begin : g_width_check
        $error("pipelined_wide_adder: WB (%0d) must not exceed WA (%0d)", WB, WA);
    end

    logic [W-1:0] a_ext;
    logic [W-1:0] b_ext;

    assign a_ext = {1'b0, in_a};
    assign b_ext = W'(in_b);

    logic [NSEG-1:0] stage_valid;
    logic [NSEG-1:0] stage_load;

    // Stage k may load unless it and every stage after it are full while the
    // consumer stalls; bubbles therefore collapse toward the output.
    // NOTE: every variable written here is assigned on each pass, so no latch is inferred.
    always_comb begin
        logic all_full;
        all_full = 1'b1;
        for (int k = NSEG - 1; k >= 0; k--) begin
            all_full      = all_full & stage_valid[k];
            stage_load[k] = out_ready | ~all_full;
        end
    end

    assign in_ready = ~rst & stage_load[0];

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        localparam int LO   = k * SEG;
        localparam int WK   = (W - LO < SEG) ? (W - LO) : SEG;
        localparam int HI   = LO + WK;
        localparam int RW   = W - LO;
        localparam bit LAST = (k == NSEG - 1);

        logic            v_src;
        logic            m_src;
        logic            c_src;
        logic [TAGW-1:0] t_src;
        logic [RW-1:0]   a_src;
        logic [RW-1:0]   b_src;
        logic [WK-1:0]   b_seg;
        logic [WK-1:0]   seg_sum;
        logic [HI-1:0]   s_nxt;

        logic            v_q;
        logic [TAGW-1:0] t_q;
        logic [HI-1:0]   s_q;

        if (k == 0) begin : g_src
            assign v_src = in_valid & in_ready;
            assign m_src = in_mode;
            assign c_src = in_mode;
            assign t_src = in_tag;
            assign a_src = a_ext;
            assign b_src = b_ext;
            assign s_nxt = seg_sum;
        end else begin : g_src
            assign v_src = g_stage[k-1].v_q;
            assign m_src = g_stage[k-1].g_fwd.m_q;
            assign c_src = g_stage[k-1].g_fwd.c_q;
            assign t_src = g_stage[k-1].t_q;
            assign a_src = g_stage[k-1].g_fwd.a_q;
            assign b_src = g_stage[k-1].g_fwd.b_q;
            assign s_nxt = {seg_sum, g_stage[k-1].s_q};
        end

        assign b_seg = b_src[WK-1:0] ^ {WK{m_src}};

        if (LAST) begin : g_fwd
            // The top carry-out is the discarded borrow/overflow of bit WA+1.
            assign seg_sum = a_src[WK-1:0] + b_seg + WK'(c_src);
        end else begin : g_fwd
            logic            co;
            logic            c_q;
            logic            m_q;
            logic [RW-WK-1:0] a_q;
            logic [RW-WK-1:0] b_q;

            assign {co, seg_sum} = {1'b0, a_src[WK-1:0]} + {1'b0, b_seg} + (WK+1)'(c_src);

            // Forward the carry, the mode and the unconsumed operand bits.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    c_q <= 1'b0;
                    m_q <= 1'b0;
                    a_q <= '0;
                    b_q <= '0;
                end else if (stage_load[k] && v_src) begin
                    c_q <= co;
                    m_q <= m_src;
                    a_q <= a_src[RW-1:WK];
                    b_q <= b_src[RW-1:WK];
                end
            end
        end

        // Stage valid, tag and completed sum bits; data only moves with a real operation.
        // NOTE: state updates use non-blocking assignments so all stages shift together on the edge.
        // NOTE: data registers are reset too, which makes out_sum/out_tag read 0 out of reset.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= 1'b0;
                t_q <= '0;
                s_q <= '0;
            end else if (stage_load[k]) begin
                v_q <= v_src;
                if (v_src) begin
                    t_q <= t_src;
                    s_q <= s_nxt;
                end
            end
        end

        assign stage_valid[k] = v_q;
    end

    assign out_valid = g_stage[NSEG-1].v_q;
    assign out_sum   = g_stage[NSEG-1].s_q;
    assign out_tag   = g_stage[NSEG-1].t_q;

endmodule

// File: tb/tb_pipelined_wide_adder.sv
// Scoreboard bench for pipelined_wide_adder with default parameters
// (WA=37, WB=35, SEG=16, three stages). Stimulus pushes hand-computed
// expected results; a monitor pops and compares whenever a result transfers.
module tb_pipelined_wide_adder;
    localparam int WA   = 37;
    localparam int WB   = 35;
    localparam int TAGW = 4;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic            in_mode;
    logic [WA-1:0]   in_a;
    logic [WB-1:0]   in_b;
    logic [TAGW-1:0] in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [WA:0]     out_sum;
    logic [TAGW-1:0] out_tag;

    pipelined_wide_adder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [TAGW-1:0] tag;
        logic [WA:0]     sum;
        int              cyc;
        bit              chk_lat;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cycle = 0;
    int          acc_count = 0;
    int          res_count = 0;
    logic [WA:0] cur_exp = '0;
    bit          cur_lat = 1'b0;
    bit          held = 1'b0;
    logic [WA:0] held_sum;
    logic [TAGW-1:0] held_tag;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cycle <= cycle + 1;

    // Record each accepted operation with its expected result.
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) begin
            sb.push_back('{tag: in_tag, sum: cur_exp, cyc: cycle, chk_lat: cur_lat});
            acc_count++;
        end
    end

    // Compare every delivered result and check output stability under stall.
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                res_count++;
                if (sb.size() == 0) begin
                    check("spurious_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check($sformatf("sum_tag%0d", e.tag), 64'(out_sum), 64'(e.sum));
                    check($sformatf("tag_order_tag%0d", e.tag), 64'(out_tag), 64'(e.tag));
                    if (e.chk_lat)
                        check($sformatf("latency_tag%0d", e.tag), 64'(cycle - e.cyc), 64'd3);
                end
            end
            if (out_valid && !out_ready) begin
                if (held) begin
                    check("stall_sum_stable", 64'(out_sum), 64'(held_sum));
                    check("stall_tag_stable", 64'(out_tag), 64'(held_tag));
                end
                held     = 1'b1;
                held_sum = out_sum;
                held_tag = out_tag;
            end else begin
                held = 1'b0;
            end
        end
    end

    // Offer one operation (called just after a rising edge) until accepted.
    task automatic send(input logic [WA-1:0] a, input logic [WB-1:0] b, input bit mode,
                        input logic [TAGW-1:0] tag, input logic [WA:0] exp_sum, input bit lat);
        bit acc;
        int guard;
        in_a     = a;
        in_b     = b;
        in_mode  = mode;
        in_tag   = tag;
        cur_exp  = exp_sum;
        cur_lat  = lat;
        in_valid = 1'b1;
        guard    = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 100);
        in_valid = 1'b0;
        check($sformatf("accepted_tag%0d", tag), 64'(acc), 64'd1);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("drain_queue_empty", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int a0;
        int r0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b1;

        // Reset state before any clock edge.
        #2;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd0);
        check("reset_out_sum", 64'(out_sum), 64'd0);
        check("reset_out_tag", 64'(out_tag), 64'd0);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("in_ready_after_reset", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Directed vectors streamed back to back, tags 0..7, latency 3 each.
        c0 = cycle;
        send(37'h1F_FFFF_FFFF, 35'h7_FFFF_FFFF, 1'b0, 4'd0, 38'h27_FFFF_FFFE, 1'b1);
        send(37'd5,            35'd7,           1'b1, 4'd1, 38'h3F_FFFF_FFFE, 1'b1);
        send(37'd7,            35'd5,           1'b1, 4'd2, 38'h00_0000_0002, 1'b1);
        send(37'hFFFF,         35'd1,           1'b0, 4'd3, 38'h00_0001_0000, 1'b1);
        send(37'hFFFF_FFFF,    35'd1,           1'b0, 4'd4, 38'h01_0000_0000, 1'b1);
        send(37'd0,            35'd0,           1'b1, 4'd5, 38'h00_0000_0000, 1'b1);
        send(37'h1F_FFFF_FFFF, 35'd0,           1'b1, 4'd6, 38'h1F_FFFF_FFFF, 1'b1);
        send(37'd0,            35'h7_FFFF_FFFF, 1'b1, 4'd7, 38'h38_0000_0001, 1'b1);
        check("stream_accept_cycles", 64'(cycle - c0), 64'd8);
        drain();

        // Backpressure: consumer stalls 5 cycles while 4 operations are offered.
        out_ready = 1'b0;
        a0 = acc_count;
        fork
            begin
                send(37'h1234,        35'd1,         1'b0, 4'd8,  38'h00_0000_1235, 1'b0);
                send(37'h10_0000_0000, 35'd1,        1'b1, 4'd9,  38'h0F_FFFF_FFFF, 1'b0);
                send(37'hAAAA_AAAA,   35'h5555_5555, 1'b0, 4'd10, 38'h00_FFFF_FFFF, 1'b0);
                send(37'h1_0000,      35'd1,         1'b1, 4'd11, 38'h00_0000_FFFF, 1'b0);
            end
            begin
                repeat (5) @(negedge clk);
                check("bp_accepts_while_stalled", 64'(acc_count - a0), 64'd3);
                check("bp_in_ready_low", 64'(in_ready), 64'd0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two operations in flight.
        send(37'd100, 35'd1, 1'b0, 4'd12, 38'd101, 1'b1);
        send(37'd200, 35'd2, 1'b0, 4'd13, 38'd202, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        check("midrst_out_sum", 64'(out_sum), 64'd0);
        check("midrst_out_tag", 64'(out_tag), 64'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_first_cycle_after_reset", 64'(in_ready), 64'd1);
        r0 = res_count;
        repeat (10) @(negedge clk);
        check("no_results_after_reset", 64'(res_count - r0), 64'd0);
        @(posedge clk);
        #1;

        // Pipeline still functional after reset.
        send(37'd3, 35'd4, 1'b0, 4'd14, 38'd7, 1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
